// File: rtl/tomasula_types.sv
// Shared types for the commit trace path: the stored record and the capture FSM states.
package tomasula_types;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned SEQ_W  = 32;
    localparam int unsigned DROP_W = 16;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              is_store;
        logic [SEQ_W-1:0]  seq;
        logic              trig;
    } trace_rec;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: single write port, asynchronous read, contents not reset.
module trace_ram
    import tomasula_types::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  trace_rec         wdata,
    input  logic [PTR_W-1:0] raddr,
    output trace_rec         rdata
);

    trace_rec mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Circular trace of retired instructions with a PC-match trigger; freezes after a
// programmable number of post-trigger commits and drains over a valid/ready port.
module commit_trace_buffer
    import tomasula_types::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              commit_valid,
    input  logic              commit_is_store,
    input  logic [PC_W-1:0]   commit_pc,
    input  logic [RD_W-1:0]   commit_rd,
    input  logic [DATA_W-1:0] commit_data,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              flush_in_prog,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [PTR_W-1:0]  post_trig,
    input  logic              trace_ready,
    output logic              trace_valid,
    output logic [PC_W-1:0]   trace_pc,
    output logic [RD_W-1:0]   trace_rd,
    output logic [DATA_W-1:0] trace_data,
    output logic [TAG_W-1:0]  trace_tag,
    output logic              trace_is_store,
    output logic [SEQ_W-1:0]  trace_seq,
    output logic              trace_trig,
    output logic [PTR_W:0]    count,
    output logic              frozen,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned CNT_W = PTR_W + 1;

    trace_state_t     state, state_nxt;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [PTR_W-1:0] post_cnt, post_cnt_nxt;
    logic [SEQ_W-1:0] seq;
    logic [CNT_W-1:0] count_nxt;
    trace_rec         head_q, new_rec, ram_rdata, head_nxt;

    logic capturing, accept, pop, full, trig_hit;
    logic write_en, overwrite, drop;

    assign capturing = (state == ARMED) || (state == POST);
    assign accept    = commit_valid && !flush_in_prog && capturing && !arm;
    assign pop       = trace_valid && trace_ready && !arm;
    assign full      = (count == CNT_W'(DEPTH));
    assign trig_hit  = accept && (state == ARMED) && trig_en && (commit_pc == trig_pc);

    // A pop in the same cycle frees a slot, so only an un-popped full buffer overwrites or discards.
    assign drop      = accept && full && !pop;
    assign overwrite = drop && (state == ARMED);
    assign write_en  = accept && !(drop && (state == POST));

    assign rd_ptr_nxt = rd_ptr + PTR_W'(pop || overwrite);
    assign wr_ptr_nxt = wr_ptr + PTR_W'(write_en);
    assign count_nxt  = count + CNT_W'(write_en && !overwrite) - CNT_W'(pop);

    always_comb begin
        new_rec          = '0;
        new_rec.pc       = commit_pc;
        new_rec.rd       = commit_rd;
        new_rec.data     = commit_data;
        new_rec.tag      = commit_tag;
        new_rec.is_store = commit_is_store;
        new_rec.seq      = seq;
        new_rec.trig     = trig_hit;
    end

    // The RAM write lands at the clock edge, so bypass a record written into the next head slot.
    always_comb begin
        head_nxt = '0;
        if (count_nxt != '0) begin
            head_nxt = (write_en && (wr_ptr == rd_ptr_nxt)) ? new_rec : ram_rdata;
        end
    end

    always_comb begin
        state_nxt    = state;
        post_cnt_nxt = post_cnt;
        if (accept) begin
            if (trig_hit) begin
                post_cnt_nxt = post_trig;
                state_nxt    = (post_trig == '0) ? FROZEN : POST;
            end else if (state == POST) begin
                post_cnt_nxt = post_cnt - PTR_W'(1);
                if (post_cnt == PTR_W'(1)) begin
                    state_nxt = FROZEN;
                end
            end
        end
    end

    trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (write_en),
        .waddr (wr_ptr),
        .wdata (new_rec),
        .raddr (rd_ptr_nxt),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            post_cnt    <= '0;
            seq         <= '0;
            count       <= '0;
            drop_cnt    <= '0;
            frozen      <= 1'b0;
            trace_valid <= 1'b0;
            head_q      <= '0;
        end else if (arm) begin
            state       <= ARMED;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            post_cnt    <= '0;
            seq         <= '0;
            count       <= '0;
            drop_cnt    <= '0;
            frozen      <= 1'b0;
            trace_valid <= 1'b0;
            head_q      <= '0;
        end else begin
            state       <= state_nxt;
            rd_ptr      <= rd_ptr_nxt;
            wr_ptr      <= wr_ptr_nxt;
            post_cnt    <= post_cnt_nxt;
            count       <= count_nxt;
            frozen      <= (state_nxt == FROZEN);
            trace_valid <= (count_nxt != '0);
            head_q      <= head_nxt;
            if (accept) begin
                seq <= seq + SEQ_W'(1);
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    assign trace_pc       = head_q.pc;
    assign trace_rd       = head_q.rd;
    assign trace_data     = head_q.data;
    assign trace_tag      = head_q.tag;
    assign trace_is_store = head_q.is_store;
    assign trace_seq      = head_q.seq;
    assign trace_trig     = head_q.trig;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Downstream consumer of the ROB commit debug signals (commit PC, rd, committed data, ROB head tag, flush status).
- Captures each retired instruction as a trace record into a circular buffer, with a sequence number attached.
- Supports a PC-match trigger. After a programmable number of post-trigger commits it freezes, so a bench or monitor can drain the pre- and post-trigger history over a valid/ready port.

Parameters:
- DEPTH, 16, number of trace entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous active-low reset
- commit_valid  input  1  ROB retires one instruction this cycle
- commit_is_store  input  1  retired instruction is a store (no rd write)
- commit_pc  input  32  PC of retired instruction
- commit_rd  input  5  destination register (store: st_src register)
- commit_data  input  32  value written to the regfile, or store data
- commit_tag  input  3  ROB head pointer of the retiring entry
- flush_in_prog  input  1  ROB flush active; commits this cycle are ignored
- arm  input  1  one-cycle pulse: clear buffer, counters and state, go to ARMED
- trig_en  input  1  enables PC-match trigger
- trig_pc  input  32  trigger PC
- post_trig  input  PTR_W  commits to capture after trigger (0 = freeze immediately after trigger record)
- trace_ready  input  1  consumer accepts the head record
- trace_valid  output  1  head record valid
- trace_pc  output  32  head record PC
- trace_rd  output  5  head record rd
- trace_data  output  32  head record data
- trace_tag  output  3  head record ROB tag
- trace_is_store  output  1  head record store flag
- trace_seq  output  32  head record sequence number
- trace_trig  output  1  head record is the trigger record
- count  output  PTR_W+1  occupied entries
- frozen  output  1  state == FROZEN
- drop_cnt  output  16  records overwritten or discarded; saturating

Behaviour:
- Reset: all outputs 0; state IDLE; pointers, sequence counter, count and drop_cnt are 0.
- FSM states:
  - IDLE: no capture; drain allowed.
  - ARMED: capture; a trigger is possible.
  - POST: capture while decrementing the post-trigger counter.
  - FROZEN: no capture; drain only.
- FSM transitions:
  - arm (any state) -> ARMED next cycle. Pointers, count, seq and drop_cnt are cleared. A commit in the arm cycle is not captured.
  - ARMED: an accepted commit with trig_en and commit_pc == trig_pc writes a record with trig bit = 1 and loads post counter = post_trig.
    - If post_trig == 0, go to FROZEN.
    - Otherwise go to POST.
  - POST: each accepted commit decrements the counter; the commit that takes it to 0 is written, then the FSM goes to FROZEN.
  - FROZEN: stays until arm.
- Accepted commit: commit_valid && !flush_in_prog && state in {ARMED, POST}.
  - Writes the record at the write pointer in the same cycle; it is visible the next cycle.
  - trace_seq = the 32-bit commit sequence counter, which wraps naturally.
  - The sequence counter increments on every accepted commit.
- Full buffer, ARMED: history mode. The oldest entry is overwritten, the read pointer advances, and drop_cnt increments; count stays DEPTH.
- Full buffer, POST: the new commit is discarded, drop_cnt increments and the post counter still decrements. Post-trigger data never evicts the trigger record.
- Drain:
  - trace_valid = (count != 0), registered.
  - Output fields come from the entry at the read pointer.
  - A pop occurs when trace_valid && trace_ready; the read pointer advances.
- Simultaneous push and pop: count unchanged. When full in ARMED with a pop in the same cycle, the pop takes precedence and there is no overwrite and no drop.
- Pointer width: pointers wrap modulo DEPTH; count has PTR_W+1 bits.
- drop_cnt saturates at 16'hFFFF.
- Reset asserted mid-drain or mid-POST: immediate return to the reset state; buffer contents are don't-care.
- Output fields must hold stable while trace_valid && !trace_ready.

Decomposition:
- Package tomasula_types gains trace_rec typedef: pc, rd, data, tag, is_store, seq, trig.
- Package tomasula_types gains enum trace_state_t {IDLE, ARMED, POST, FROZEN}.
- Sub-module trace_ram: DEPTH x trace_rec storage, one write port, asynchronous read at the read pointer, no reset on contents.
- The FSM, pointers and counters live in the top module.

Test Plan:
- Reset, then 3 commits with no arm -> trace_valid stays 0, count 0, drop_cnt 0.
- arm; 5 commits, PCs 0x60..0x70 step 4; trace_ready=1 -> 5 records in order, seq 0..4, trig bits 0.
- arm, DEPTH=16, trace_ready=0, 20 commits -> count 16, drop_cnt 4, first record popped has seq 4 and its PC is the 5th commit's PC.
- arm, trig_en=1, trig_pc=0x84, post_trig=2; commits 0x80, 0x84, 0x88, 0x8C, 0x90 -> frozen after 0x8C; 4 records; record 0x84 has trig=1; 0x90 is not captured and drop_cnt stays 0.
- arm; commit_valid with flush_in_prog=1 for 2 cycles, then 1 clean commit -> only 1 record with seq 0.
- Full buffer in ARMED, push and pop in the same cycle -> count remains 16, drop_cnt unchanged. Then assert reset_n low mid-drain -> all outputs 0 within the same cycle.
